serial_complementer: RTL and testbench

Parametrised bit-serial complementer for LSB-first word streams. It produces either the one's complement or the two's complement of each WIDTH-bit word, selected per word. It generalises the earlier single-mode one's-complement FSM with word framing, a valid/stall handshake, an abort input and an overflow flag. It sits in the serial datapath between a bit-serial source and any downstream serial consumer.

---
 rtl/serial_complementer.sv | 106 ++++++++++
 tb/tb_serial_complementer.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/serial_complementer.sv
// serial_complementer: bit-serial one's/two's complementer for LSB-first WIDTH-bit words.
// Latency: every output is registered, so it appears one cycle after the accepted input bit.
// Backpressure: none. in_valid=0 stalls the word in place. clear aborts the current word and drops its bit.
// Ports:
//   clk, rst          - clock and asynchronous active-high reset
//   mode              - 0 = one's complement, 1 = two's complement; latched on the first bit of a word
//   clear             - synchronous abort; takes priority over in_valid
//   in_valid, in_data - serial input bit, LSB first
//   out_valid, out_data, word_done, ovf - registered serial output, end-of-word pulse, overflow flag
module serial_complementer #(
  parameter int WIDTH = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic mode,
  input  logic clear,
  input  logic in_valid,
  input  logic in_data,
  output logic out_valid,
  output logic out_data,
  output logic word_done,
  output logic ovf
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    COPY   = 2'd1,
    INVERT = 2'd2
  } state_t;

  state_t        state, state_next;
  logic [CW-1:0] cnt, cnt_next;
  logic          mode_q, mode_q_next;
  logic          out_valid_next, out_data_next, word_done_next, ovf_next;

  logic accept;
  logic last;
  logic pass_through;

  assign accept = in_valid & ~clear;
  assign last   = (cnt == LAST);

  // The bit passes through unchanged only while a two's-complement word has not
  // yet seen a 1. On the first bit the live mode input decides this, because
  // mode_q is only captured on that same edge.
  assign pass_through = (state == IDLE) ? mode : (state == COPY);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      mode_q    <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= 1'b0;
      word_done <= 1'b0;
      ovf       <= 1'b0;
    end else begin
      state     <= state_next;
      cnt       <= cnt_next;
      mode_q    <= mode_q_next;
      out_valid <= out_valid_next;
      out_data  <= out_data_next;
      word_done <= word_done_next;
      ovf       <= ovf_next;
    end
  end

  always_comb begin
    state_next     = state;
    cnt_next       = cnt;
    mode_q_next    = mode_q;
    out_valid_next = 1'b0;
    out_data_next  = 1'b0;
    word_done_next = 1'b0;
    ovf_next       = 1'b0;

    if (clear) begin
      // The partial word is dropped: nothing is emitted for this cycle.
      state_next = IDLE;
      cnt_next   = '0;
    end else if (accept) begin
      if (state == IDLE) begin
        mode_q_next = mode;
      end
      out_valid_next = 1'b1;
      out_data_next  = pass_through ? in_data : ~in_data;

      if (last) begin
        word_done_next = 1'b1;
        // A 1 arriving in the MSB while still copying means the word was
        // 1 followed by zeros: the most negative value, whose negation has no
        // representation in WIDTH bits.
        ovf_next   = mode_q & in_data & (state == COPY);
        cnt_next   = '0;
        state_next = IDLE;
      end else begin
        cnt_next   = cnt + 1'b1;
        state_next = (pass_through && !in_data) ? COPY : INVERT;
      end
    end
  end

endmodule

// File: tb/tb_serial_complementer.sv
module tb_serial_complementer;

  logic clk = 1'b0;
  logic rst;
  logic mode, clear, in_valid, in_data;
  logic out_valid, out_data, word_done, ovf;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  serial_complementer #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .mode      (mode),
    .clear     (clear),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_data  (out_data),
    .word_done (word_done),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic       md;
    logic [7:0] w;
    logic [7:0] exp;
    logic       eovf;
  } vec_t;

  task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Sends one word LSB first. stall[c]=1 holds in_valid low on cycle c.
  // mode is flipped on every cycle after the first bit to prove it is latched.
  task automatic run_word(input logic md, input logic [7:0] w, input logic [7:0] exp,
                          input logic eovf, input logic [15:0] stall, output int done_cyc);
    logic [7:0] got;
    int b;
    int c;
    got = '0;
    b = 0;
    c = 0;
    done_cyc = -1;
    while (b < 8 && c < 16) begin
      in_valid = ~stall[c];
      in_data  = w[b];
      mode     = (b == 0) ? md : ~md;
      clear    = 1'b0;
      @(posedge clk); #1;
      if (stall[c]) begin
        chk("stall_quiet", {4'b0, out_valid, out_data, word_done, ovf}, 8'h00);
      end else begin
        chk("out_valid", {7'b0, out_valid}, 8'h01);
        got[b] = out_data;
        chk("word_done", {7'b0, word_done}, {7'b0, (b == 7)});
        if (b == 7) begin
          chk("ovf", {7'b0, ovf}, {7'b0, eovf});
          done_cyc = cyc;
        end
        b++;
      end
      c++;
    end
    if (b != 8) chk("word_timeout", 8'(b), 8'd8);
    in_valid = 1'b0;
    chk("word", got, exp);
  endtask

  // Accepted bits whose result is discarded by an abort that follows.
  task automatic send_bits(input logic md, input logic [7:0] w, input int n);
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b1;
      in_data  = w[i];
      mode     = md;
      clear    = 1'b0;
      @(posedge clk); #1;
      chk("pre_abort_valid", {7'b0, out_valid}, 8'h01);
    end
  endtask

  vec_t tbl[6];
  int d0, d1;

  initial begin
    tbl[0] = '{md: 1'b0, w: 8'h5A, exp: 8'hA5, eovf: 1'b0};
    tbl[1] = '{md: 1'b1, w: 8'h58, exp: 8'hA8, eovf: 1'b0};
    tbl[2] = '{md: 1'b1, w: 8'h01, exp: 8'hFF, eovf: 1'b0};
    tbl[3] = '{md: 1'b1, w: 8'hFF, exp: 8'h01, eovf: 1'b0};
    tbl[4] = '{md: 1'b1, w: 8'h00, exp: 8'h00, eovf: 1'b0};
    tbl[5] = '{md: 1'b1, w: 8'h80, exp: 8'h80, eovf: 1'b1};

    rst = 1'b1;
    mode = 1'b0;
    clear = 1'b0;
    in_valid = 1'b1;
    in_data = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", {4'b0, out_valid, out_data, word_done, ovf}, 8'h00);
    rst = 1'b0;
    in_valid = 1'b0;
    @(posedge clk); #1;
    chk("idle_outputs", {4'b0, out_valid, out_data, word_done, ovf}, 8'h00);

    // Table vectors, applied back-to-back.
    for (int i = 0; i < 6; i++) begin
      run_word(tbl[i].md, tbl[i].w, tbl[i].exp, tbl[i].eovf, 16'h0000, d0);
    end

    // Stalls on cycles 3, 4 and 7 of the word, mode toggling mid-word.
    run_word(1'b1, 8'h3C, 8'hC4, 1'b0, 16'h004C, d0);

    // Back-to-back words: done pulses exactly 8 cycles apart.
    run_word(1'b0, 8'h5A, 8'hA5, 1'b0, 16'h0000, d0);
    run_word(1'b1, 8'h58, 8'hA8, 1'b0, 16'h0000, d1);
    chk("done_spacing", 8'(d1 - d0), 8'd8);

    // Asynchronous reset mid-word after 3 bits.
    @(posedge clk); #1;
    send_bits(1'b0, 8'h00, 3);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_outputs", {4'b0, out_valid, out_data, word_done, ovf}, 8'h00);
    in_valid = 1'b1;
    @(posedge clk); #1;
    chk("rst_held_outputs", {4'b0, out_valid, out_data, word_done, ovf}, 8'h00);
    rst = 1'b0;
    run_word(1'b1, 8'h01, 8'hFF, 1'b0, 16'h0000, d0);

    // clear after 5 bits, with in_valid high on the clear cycle.
    send_bits(1'b0, 8'h00, 5);
    in_valid = 1'b1;
    in_data  = 1'b0;
    clear    = 1'b1;
    @(posedge clk); #1;
    chk("clear_outputs", {4'b0, out_valid, out_data, word_done, ovf}, 8'h00);
    clear = 1'b0;
    run_word(1'b1, 8'h01, 8'hFF, 1'b0, 16'h0000, d0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
